// File: rtl/shift_pkg.sv
// shift_pkg
// Types and constants shared by the shift-register family: the
// parallel-in/serial-out transmitter (piso_tx) and the serial-in shift
// register testbenches that check bit direction against it.
//
// Contents:
//   piso_state_t   - transmitter FSM states {IDLE, SHIFT, DONE}
//   DIR_LSB_FIRST  - dir value for LSB-first (right shift) ordering
//   DIR_MSB_FIRST  - dir value for MSB-first (left shift) ordering
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage : shift_pkg

// File: rtl/piso_tx.sv
// piso_tx
// Parallel-in/serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and emitted one bit per enabled cycle, MSB-first or
// LSB-first, framed by a frame_start strobe on the first bit and a one-cycle
// done pulse after the last bit has been consumed.
//
// Parameters:
//   WIDTH        word length in bits (>= 2)
// Ports:
//   clk          clock, rising edge
//   arstn        asynchronous active-low reset
//   load_valid   load_data is presented
//   load_ready   word can be accepted (FSM is IDLE)
//   load_data    word to serialize, held until accepted
//   dir          1 = MSB-first, 0 = LSB-first; sampled at acceptance only
//   en           bit strobe; current bit consumed on en=1 while shifting
//   s_out        serial data (0 outside a frame)
//   s_valid      s_out carries a frame bit
//   frame_start  first bit of a frame is on s_out
//   done         one-cycle pulse after the last bit is consumed
module piso_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             en,
  output logic             s_out,
  output logic             s_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  // Counter value while the first bit of a frame is on the line.
  localparam logic [CW-1:0] CNT_FIRST = CW'(WIDTH - 1);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic             dir_q;
  logic [CW-1:0]    bit_cnt;

  logic accept;
  logic in_shift;
  logic cur_bit;

  assign accept   = load_valid && (state == IDLE);
  assign in_shift = (state == SHIFT);
  // The bit on the line is always at the end the register shifts toward,
  // so no separate bit index is needed.
  assign cur_bit  = dir_q ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= IDLE;
      shreg   <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= load_data;
            dir_q   <= dir;
            bit_cnt <= CNT_FIRST;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (en) begin
            if (bit_cnt == '0) begin
              // Last bit consumed; the register contents no longer matter.
              state <= DONE;
            end else begin
              if (dir_q == DIR_MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
              end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
              end
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registered state, so an asynchronous
  // reset clears them immediately and no input reaches them combinationally.
  assign load_ready  = (state == IDLE);
  assign s_valid     = in_shift;
  assign s_out       = in_shift & cur_bit;
  assign frame_start = in_shift && (bit_cnt == CNT_FIRST);
  assign done        = (state == DONE);

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// tb_piso_tx
// Directed bench for piso_tx (WIDTH=8). Every accepted word pushes its
// expected bit sequence onto a scoreboard queue; a monitor compares the
// serial line against the queue head on every s_valid cycle and pops it on
// enabled cycles. The main sequence checks frame timing (done, load_ready,
// s_valid) cycle by cycle relative to the acceptance edge.
module tb_piso_tx;
  import shift_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         arstn;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         dir;
  logic         en;
  logic         s_out;
  logic         s_valid;
  logic         frame_start;
  logic         done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic b;
    logic first;
  } exp_bit_t;

  exp_bit_t exp_q[$];

  piso_tx #(.WIDTH(W)) dut (
    .clk         (clk),
    .arstn       (arstn),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .dir         (dir),
    .en          (en),
    .s_out       (s_out),
    .s_valid     (s_valid),
    .frame_start (frame_start),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bit order for one word, first transmitted bit first.
  task automatic push_word(input logic [W-1:0] d, input logic dr);
    exp_bit_t e;
    for (int i = 0; i < W; i++) begin
      e.b     = (dr == DIR_MSB_FIRST) ? d[W-1-i] : d[i];
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Serial-line monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_bit_t h;
    if (s_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 32'(s_valid), 32'd0);
      end else begin
        h = exp_q[0];
        chk("s_out", 32'(s_out), 32'(h.b));
        chk("frame_start", 32'(frame_start), 32'(h.first));
        if (en === 1'b1) void'(exp_q.pop_front());
      end
    end else begin
      chk("s_out_idle", 32'(s_out), 32'd0);
      chk("frame_start_idle", 32'(frame_start), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called mid-cycle while the DUT is IDLE; the following edge accepts.
  // On return it is cycle N+1 relative to acceptance edge N.
  task automatic send(input logic [W-1:0] d, input logic dr);
    chk("load_ready_before_send", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = d;
    dir        = dr;
    push_word(d, dr);
    step();
    load_valid = 1'b0;
  endtask

  // Walks a frame from cycle N+1 to the cycle load_ready returns.
  // gate=1 holds en low on odd cycles so every bit is shown for two cycles.
  // inj_c>0 presents a new word (held) from that cycle on; it may only be
  // accepted once the FSM is back in IDLE.
  task automatic run(input int exp_done, input bit gate, input int inj_c,
                     input logic [W-1:0] inj_d, input logic inj_dir);
    for (int c = 1; c <= exp_done + 1; c++) begin
      chk($sformatf("done_c%0d", c), 32'(done), 32'(c == exp_done));
      chk($sformatf("load_ready_c%0d", c), 32'(load_ready), 32'(c == exp_done + 1));
      chk($sformatf("s_valid_c%0d", c), 32'(s_valid), 32'(c < exp_done));
      en = gate ? ((c % 2) == 0) : 1'b1;
      if (c == inj_c) begin
        load_valid = 1'b1;
        load_data  = inj_d;
        dir        = inj_dir;
        push_word(inj_d, inj_dir);
      end
      if (c <= exp_done) step();
    end
  endtask

  initial begin
    arstn      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    dir        = 1'b0;
    en         = 1'b0;
    #1;
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    step();
    step();
    arstn = 1'b1;
    step();
    $display("txn: reset released");

    // MSB-first: 0,0,0,1,1,1,1,0; done at N+9, ready at N+10.
    send(8'h1E, DIR_MSB_FIRST);
    run(9, 1'b0, 0, '0, 1'b0);
    $display("txn: msb-first 8'h1E");

    // LSB-first: 0,1,1,1,1,0,0,0.
    send(8'h1E, DIR_LSB_FIRST);
    run(9, 1'b0, 0, '0, 1'b0);
    $display("txn: lsb-first 8'h1E");

    // Enable gating: 16 SHIFT cycles, done at N+17.
    send(8'hA5, DIR_MSB_FIRST);
    run(17, 1'b1, 0, '0, 1'b0);
    $display("txn: gated msb-first 8'hA5");

    // Busy-ignore: 8'hFF/LSB presented mid-frame, accepted only after DONE.
    send(8'h0F, DIR_MSB_FIRST);
    run(9, 1'b0, 3, 8'hFF, DIR_LSB_FIRST);
    step();
    load_valid = 1'b0;
    run(9, 1'b0, 0, '0, 1'b0);
    $display("txn: busy-ignore 8'h0F then 8'hFF");

    // Reset after three bits have been consumed.
    en = 1'b1;
    send(8'h5A, DIR_MSB_FIRST);
    step();
    step();
    step();
    arstn = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_s_out", 32'(s_out), 32'd0);
    chk("midrst_load_ready", 32'(load_ready), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    step();
    chk("midrst_done_hold", 32'(done), 32'd0);
    arstn = 1'b1;
    chk("postrst_done", 32'(done), 32'd0);
    step();
    chk("postrst_done2", 32'(done), 32'd0);
    send(8'h81, DIR_MSB_FIRST);
    run(9, 1'b0, 0, '0, 1'b0);
    $display("txn: reset mid-frame then 8'h81");

    // Back-to-back with load_valid held: s_valid low at N+9 and N+10 only.
    send(8'h0F, DIR_MSB_FIRST);
    run(9, 1'b0, 1, 8'hF0, DIR_MSB_FIRST);
    step();
    load_valid = 1'b0;
    run(9, 1'b0, 0, '0, 1'b0);
    $display("txn: back-to-back 8'h0F, 8'hF0");

    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_piso_tx
